// File: rtl/md_unit_xlen_if.sv
// Start/busy/done handshake bundle between the control FSM and md_unit_xlen.
//   start   ctrl -> unit  request; accepted only while the unit is idle or done
//   funct3  ctrl -> unit  operation select (RISC-V M-extension encoding)
//   opa     ctrl -> unit  rs1 operand (multiplicand / dividend)
//   opb     ctrl -> unit  rs2 operand (multiplier / divisor)
//   busy    unit -> ctrl  operation in progress
//   done    unit -> ctrl  one-cycle pulse, result valid
//   result  unit -> ctrl  result, held until the next accepted start
interface md_unit_xlen_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, opa, opb,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, opa, opb,
    output busy, done, result
  );
endinterface

// File: rtl/md_unit_xlen.sv
// Multicycle RISC-V M-extension multiply/divide unit, one result bit per cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    md_unit_xlen_if.slave (start/funct3/opa/opb in, busy/done/result out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | XLEN shift-add or restoring-divide iterations on magnitudes
// FIX   | sign correction and result select
// DONE  | done pulse; start here is accepted (back-to-back)
module md_unit_xlen #(
  parameter int XLEN = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  md_unit_xlen_if.slave bus
);

  localparam int                CW       = $clog2(XLEN);
  localparam logic [CW-1:0]     LAST     = CW'(XLEN - 1);
  localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   opb_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   result_q;

  // accept-time decode
  logic            accept;
  logic            sgn_a_in, sgn_b_in;
  logic            neg_a_in, neg_b_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            div_zero, div_ovf, special_in;
  logic [XLEN-1:0] special_res;

  assign accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
  // signed rs2: MULH, DIV, REM; signed rs1 additionally MULHSU
  assign sgn_b_in = (bus.funct3 == 3'b001) || (bus.funct3[2] && !bus.funct3[0]);
  assign sgn_a_in = sgn_b_in || (bus.funct3 == 3'b010);
  assign neg_a_in = sgn_a_in && bus.opa[XLEN-1];
  assign neg_b_in = sgn_b_in && bus.opb[XLEN-1];
  assign mag_a_in = neg_a_in ? ('0 - bus.opa) : bus.opa;
  assign mag_b_in = neg_b_in ? ('0 - bus.opb) : bus.opb;

  assign div_zero   = bus.funct3[2] && (bus.opb == '0);
  assign div_ovf    = bus.funct3[2] && !bus.funct3[0] &&
                      (bus.opa == MOST_NEG) && (bus.opb == '1);
  assign special_in = div_zero || div_ovf;

  always_comb begin
    special_res = '1;
    if (div_zero)
      special_res = bus.funct3[1] ? bus.opa : '1;
    else
      special_res = bus.funct3[1] ? '0 : bus.opa;
  end

  // iteration step: acc = {hi, lo}; lo holds multiplier / dividend bits
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_rs, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // remainder stays below the divisor, so bit XLEN of the difference is the borrow
  assign div_rs   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = div_rs - {1'b0, opb_q};
  assign div_ge   = !div_diff[XLEN];
  assign div_next = {(div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0]),
                     acc[XLEN-2:0], div_ge};

  // sign correction
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign prod = (neg_a ^ neg_b) ? ('0 - acc) : acc;
  assign quo  = (neg_a ^ neg_b) ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
  assign rem  = neg_a ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = prod[2*XLEN-1:XLEN];
    if (op[2])
      fix_res = op[1] ? rem : quo;
    else if (op[1:0] == 2'b00)
      fix_res = prod[XLEN-1:0];
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start)
          state_nxt = special_in ? S_DONE : S_RUN;
        else
          state_nxt = S_IDLE;
      end
      S_RUN:   if (cnt == LAST) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      opb_q    <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (accept) begin
      if (special_in) begin
        result_q <= special_res;
      end else begin
        op    <= bus.funct3;
        neg_a <= neg_a_in;
        neg_b <= neg_b_in;
        opb_q <= mag_b_in;
        acc   <= {{XLEN{1'b0}}, mag_a_in};
        cnt   <= '0;
      end
    end else if (state == S_RUN) begin
      acc <= op[2] ? div_next : mul_next;
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end else if (state == S_FIX) begin
      result_q <= fix_res;
    end
  end

  assign bus.busy   = (state == S_RUN) || (state == S_FIX);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_md_unit_xlen.sv
// Scoreboard bench for md_unit_xlen at XLEN=64 and XLEN=32.
module tb_md_unit_xlen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  md_unit_xlen_if #(.XLEN(64)) if64 ();
  md_unit_xlen_if #(.XLEN(32)) if32 ();

  md_unit_xlen #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));
  md_unit_xlen #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  typedef struct {
    logic [63:0] res;
    int          e0;
    int          lat;
    int          busy;
    string       name;
  } exp_t;

  exp_t q64[$];
  exp_t q32[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   dones64 = 0;
  int   dones32 = 0;
  int   busy64_cnt = 0;
  int   busy32_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // reference: plain wide arithmetic on sign/zero-extended operands
  function automatic logic [63:0] ref_model(int w, bit [2:0] f3, logic [63:0] a_in, logic [63:0] b_in);
    logic [63:0]        mask, a, b, r;
    logic signed [127:0] sa, sb, ua, ub, p, min_neg;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a = a_in & mask;
    b = b_in & mask;
    ua = {64'd0, a};
    ub = {64'd0, b};
    sa = (w == 64) ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
    sb = (w == 64) ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
    min_neg = -(128'sd1 <<< (w - 1));
    r = 64'd0;
    case (f3)
      3'd0: begin p = ua * ub; r = p[63:0]; end
      3'd1: begin p = sa * sb; p = p >>> w; r = p[63:0]; end
      3'd2: begin p = sa * ub; p = p >>> w; r = p[63:0]; end
      3'd3: begin p = ua * ub; p = p >>> w; r = p[63:0]; end
      3'd4: begin
        if (b == 0) r = mask;
        else if (sa == min_neg && sb == -128'sd1) r = a;
        else begin p = sa / sb; r = p[63:0]; end
      end
      3'd5: begin
        if (b == 0) r = mask;
        else begin p = ua / ub; r = p[63:0]; end
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (sa == min_neg && sb == -128'sd1) r = 64'd0;
        else begin p = sa % sb; r = p[63:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[63:0]; end
      end
    endcase
    return r & mask;
  endfunction

  function automatic bit is_special(int w, bit [2:0] f3, logic [63:0] a_in, logic [63:0] b_in);
    logic [63:0] mask, a, b, one;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    one = 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (!f3[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return (!f3[0] && a == (one << (w - 1)) && b == mask);
  endfunction

  function automatic logic [63:0] rnd_op(int w);
    logic [63:0] v, one;
    one = 64'd1;
    case ($urandom_range(0, 7))
      0: v = 64'd0;
      1: v = '1;
      2: v = one << (w - 1);
      3: v = 64'($urandom_range(0, 20));
      4: v = 64'd0 - 64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom};
    endcase
    return (w == 64) ? v : (v & 64'h0000_0000_FFFF_FFFF);
  endfunction

  // called at a negedge; returns one negedge after the accept edge
  task automatic issue(int w, bit [2:0] f3, logic [63:0] a, logic [63:0] b,
                       logic [63:0] req, string nm);
    exp_t e;
    bit   sp;
    sp     = is_special(w, f3, a, b);
    e.res  = req;
    e.e0   = cyc + 1;
    e.lat  = sp ? 0 : w + 1;
    e.busy = sp ? 0 : w + 1;
    e.name = nm;
    if (w == 64) begin
      if64.funct3 = f3; if64.opa = a; if64.opb = b; if64.start = 1'b1;
      q64.push_back(e);
    end else begin
      if32.funct3 = f3; if32.opa = a[31:0]; if32.opb = b[31:0]; if32.start = 1'b1;
      q32.push_back(e);
    end
    @(negedge clk);
    if (w == 64) begin
      if64.start = 1'b0; if64.funct3 = 3'($urandom); if64.opa = {$urandom, $urandom}; if64.opb = {$urandom, $urandom};
    end else begin
      if32.start = 1'b0; if32.funct3 = 3'($urandom); if32.opa = $urandom; if32.opb = $urandom;
    end
  endtask

  // returns at the negedge where done is observed
  task automatic wait_done(int w, string nm);
    for (int i = 0; i < 200; i++) begin
      if ((w == 64 && if64.done) || (w == 32 && if32.done)) return;
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=no_done required=done_within_200", nm);
  endtask

  task automatic run_op(int w, bit [2:0] f3, logic [63:0] a, logic [63:0] b,
                        logic [63:0] req, string nm);
    @(negedge clk);
    issue(w, f3, a, b, req, nm);
    wait_done(w, nm);
  endtask

  // monitors: pop one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) busy64_cnt = 0;
    else if (if64.busy) busy64_cnt++;
    if (if64.done) begin
      dones64++;
      chk("busy_with_done64", 64'(if64.busy), 64'd0);
      if (q64.size() == 0) begin
        chk("unexpected_done64", 64'd1, 64'd0);
      end else begin
        e = q64.pop_front();
        chk({e.name, "_result"}, if64.result, e.res);
        chk({e.name, "_latency"}, 64'(cyc - e.e0), 64'(e.lat));
        chk({e.name, "_busy_cycles"}, 64'(busy64_cnt), 64'(e.busy));
      end
      busy64_cnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) busy32_cnt = 0;
    else if (if32.busy) busy32_cnt++;
    if (if32.done) begin
      dones32++;
      chk("busy_with_done32", 64'(if32.busy), 64'd0);
      if (q32.size() == 0) begin
        chk("unexpected_done32", 64'd1, 64'd0);
      end else begin
        e = q32.pop_front();
        chk({e.name, "_result"}, {32'd0, if32.result}, e.res);
        chk({e.name, "_latency"}, 64'(cyc - e.e0), 64'(e.lat));
        chk({e.name, "_busy_cycles"}, 64'(busy32_cnt), 64'(e.busy));
      end
      busy32_cnt = 0;
    end
  end

  localparam bit [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                       DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  initial begin
    int d64, d32;
    if64.start = 1'b0; if64.funct3 = 3'd0; if64.opa = '0; if64.opb = '0;
    if32.start = 1'b0; if32.funct3 = 3'd0; if32.opa = '0; if32.opb = '0;

    #3;
    chk("reset_busy", 64'(if64.busy), 64'd0);
    chk("reset_done", 64'(if64.done), 64'd0);
    chk("reset_result", if64.result, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(64, MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "mul_7_m3");
    run_op(64, MULHU,  ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu_ones");
    run_op(64, MULH,   ONES, ONES, 64'd0, "mulh_ones");
    run_op(64, MULHSU, ONES, 64'd2, ONES, "mulhsu_m1_2");
    run_op(64, DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2");
    run_op(64, REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, "rem_m7_2");
    run_op(64, DIVU,   64'd100, 64'd7, 64'd14, "divu_100_7");
    run_op(64, REMU,   64'd100, 64'd7, 64'd2, "remu_100_7");
    run_op(64, DIV,    64'd5, 64'd0, ONES, "div_by_zero");
    run_op(64, REMU,   64'd5, 64'd0, 64'd5, "remu_by_zero");
    run_op(64, DIV,    MIN64, ONES, MIN64, "div_overflow");
    run_op(64, REM,    MIN64, ONES, 64'd0, "rem_overflow");

    // start while busy must be ignored
    @(negedge clk);
    issue(64, DIVU, 64'd100, 64'd7, 64'd14, "divu_ignored_start");
    repeat (8) @(negedge clk);
    if64.funct3 = MUL; if64.opa = 64'd1000; if64.opb = 64'd3; if64.start = 1'b1;
    @(negedge clk);
    if64.start = 1'b0;
    wait_done(64, "divu_ignored_start");

    // back-to-back: second start during the done cycle
    @(negedge clk);
    issue(64, MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "b2b_first");
    wait_done(64, "b2b_first");
    issue(64, DIVU, 64'd100, 64'd7, 64'd14, "b2b_second");
    wait_done(64, "b2b_second");

    run_op(32, DIV,  64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, "x32_div_overflow");
    run_op(32, MULH, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, "x32_mulh_min");

    // reset in the middle of a multiply
    @(negedge clk);
    issue(64, MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "mul_aborted");
    repeat (28) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(if64.busy), 64'd0);
    chk("abort_done", 64'(if64.done), 64'd0);
    chk("abort_result", if64.result, 64'd0);
    chk("abort_result32", {32'd0, if32.result}, 64'd0);
    q64.delete();
    d64 = dones64;
    d32 = dones32;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_no_done", 64'(dones64 - d64), 64'd0);
    chk("abort_no_done32", 64'(dones32 - d32), 64'd0);

    for (int i = 0; i < 40; i++) begin
      bit [2:0]    f;
      logic [63:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = rnd_op(64);
      b = rnd_op(64);
      run_op(64, f, a, b, ref_model(64, f, a, b), "rand64");
    end

    for (int i = 0; i < 25; i++) begin
      bit [2:0]    f;
      logic [63:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = rnd_op(32);
      b = rnd_op(32);
      run_op(32, f, a, b, ref_model(32, f, a, b), "rand32");
    end

    repeat (3) @(negedge clk);
    chk("queue64_drained", 64'(q64.size()), 64'd0);
    chk("queue32_drained", 64'(q32.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_unit_xlen.md
# md_unit_xlen

Parametrised multicycle integer multiply/divide unit implementing the full RISC-V M-extension operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a configurable data width. It sits beside `ula64` in the multicycle datapath and is driven by the control state machine through a START/BUSY/DONE handshake. Operand A comes from the A register and operand B from the B register; RESULT feeds the register-file write-data mux. Iterative shift-add and restoring-division hardware gives one result bit per cycle.

## Interface
- XLEN, 64, operand and result width; legal values 32 or 64.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous and active-low.
- START  in  1  request; sampled only when the unit is idle or in DONE.
- FUNCT3  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPA  in  XLEN  rs1 operand (dividend or multiplicand).
- OPB  in  XLEN  rs2 operand (divisor or multiplier).
- BUSY  out  1  high while an operation is in progress (RUN or FIX).
- DONE  out  1  one-cycle pulse; RESULT is valid during this cycle.
- RESULT  out  XLEN  result; held stable until the next accepted START.

## Operation
- States:
  - IDLE: waits for START.
  - RUN: iterates; a counter runs from 0 to XLEN-1.
  - FIX: applies sign correction and selects the result.
  - DONE: asserts DONE for one cycle.
- Accept: START=1 in IDLE or DONE latches FUNCT3, OPA and OPB. START while BUSY=1 is ignored and has no side effect.
- Signedness:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats only OPA as signed.
  - MUL, MULHU, DIVU and REMU treat both as unsigned. MUL result bits are sign-independent.
- Magnitudes: negative signed operands are converted to two's-complement magnitude at accept time, and the sign flags are stored.
- Multiply:
  - A 2*XLEN accumulator performs XLEN shift-add steps on the magnitudes.
  - FIX negates the full 2*XLEN product when the sign flags differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - XLEN restoring steps on the magnitudes.
  - In FIX, the quotient is negated if sign(A)^sign(B), and the remainder takes the sign of A.
- Special cases are resolved at accept time with no RUN phase:
  - Divide by zero (OPB=0, any DIV/DIVU/REM/REMU): quotient is all ones; remainder is OPA.
  - Signed overflow (DIV/REM with OPA = most negative, OPB = -1): quotient is OPA; remainder is 0.
- Reset (RST=0, at any time, including mid-operation): state IDLE, counter 0, BUSY=0, DONE=0, RESULT=0, all internal registers cleared. The aborted operation produces no DONE.

## Timing
- Normal path, with START sampled at edge E0:
  - E0: IDLE/DONE -> RUN; BUSY=1.
  - E1..E_XLEN: one iteration per edge; the transition RUN -> FIX happens at E_XLEN.
  - E_XLEN+1: FIX -> DONE; RESULT is updated, BUSY=0 and DONE=1.
  - E_XLEN+2: DONE -> IDLE, or -> RUN if START=1 (back-to-back).
  - Latency from START edge to DONE high is XLEN+1 edges (65 for XLEN=64).
- Special-case path: START at E0 goes directly to DONE. RESULT is valid and DONE=1 after E0, and BUSY never rises.
- DONE and BUSY are Moore outputs, decoded from state only. They are never high together.
- RESULT changes only on the edge that enters DONE or on reset.
- OPA, OPB and FUNCT3 may change freely after the accept edge.

## Test plan
- MUL, OPA=7, OPB=-3 (0xFFFF_FFFF_FFFF_FFFD) -> RESULT=0xFFFF_FFFF_FFFF_FFEB; DONE 65 edges after START; BUSY high for exactly 65 cycles.
- MULHU, OPA=OPB=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. Then MULH with the same operands -> 0. Then MULHSU, OPA=-1, OPB=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV, OPA=-7, OPB=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1). DIVU, OPA=100, OPB=7 -> 14; REMU -> 2.
- Special cases:
  - DIV 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
  - REMU 5/0 -> 5.
  - DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
  - REM with the same operands -> 0.
  - Each gives DONE 1 edge after START, with BUSY staying 0.
- Handshake:
  - START pulsed at cycle 10 of a DIVU 100/7: ignored, result still 14.
  - Back-to-back: a new START during the DONE cycle yields the second result 65 edges later.
  - RST low at cycle 30 of a MUL: BUSY, DONE and RESULT go to 0 immediately (asynchronously), and no DONE pulse follows.
- XLEN=32 instance:
  - MULH 0x8000_0000 * 0x8000_0000 -> 0x4000_0000.
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000.
  - DONE 33 edges after START on the normal path.
